normalizer_pipe: RTL and testbench

- Parametrised, pipelined successor of the Chebyshev datapath's combinational normalizer.
- Takes an unsigned fixed-point operand with W total bits and F fraction bits. Shifts it so its leading one lands at bit F, i.e. the value lies in [1,2).
- Reports the shift amount and direction, plus zero and sticky flags, so the downstream polynomial stage can denormalise.
- Two-stage pipeline with valid/ready handshake and full back-pressure. A tag field rides alongside each operand.

---
 rtl/normalizer_pipe.sv | 119 +++++++++++
 tb/tb_normalizer_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalizer_pipe.sv
// Two-stage pipelined normalizer: shifts an unsigned Q(W-F).F operand so its leading one sits at bit F,
// reporting shift amount, direction, zero and sticky flags with a valid/ready handshake and a passthrough tag.
module normalizer_pipe #(
  parameter int unsigned W  = 18,
  parameter int unsigned F  = 12,
  parameter int unsigned TW = 4,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_y,
  output logic [SW-1:0] out_shift,
  output logic          out_lr,
  output logic          out_zero,
  output logic          out_sticky,
  output logic [TW-1:0] out_tag
);

  localparam logic [SW-1:0] FPOS = SW'(F);

  logic          en1;
  logic          en2;
  logic          s1_valid;
  logic [W-1:0]  s1_x;
  logic [TW-1:0] s1_tag;
  logic [SW-1:0] s1_shift;
  logic          s1_lr;
  logic          s1_zero;

  logic [SW-1:0] lead_pos;
  logic          in_zero;
  logic [SW-1:0] shift_c;
  logic          lr_c;
  logic [W-1:0]  y_c;
  logic          sticky_c;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // Leading-one detector: the highest set bit wins.
  always_comb begin
    lead_pos = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (in_x[i]) lead_pos = SW'(i);
    end
  end

  assign in_zero = ~|in_x;

  // Shift magnitude and direction needed to move the leading one to bit F.
  always_comb begin
    shift_c = '0;
    lr_c    = 1'b0;
    if (!in_zero) begin
      if (lead_pos > FPOS) begin
        shift_c = lead_pos - FPOS;
        lr_c    = 1'b1;
      end else begin
        shift_c = FPOS - lead_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_tag   <= '0;
      s1_shift <= '0;
      s1_lr    <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x     <= in_x;
        s1_tag   <= in_tag;
        s1_shift <= shift_c;
        s1_lr    <= lr_c;
        s1_zero  <= in_zero;
      end
    end
  end

  // Barrel shift; sticky collects the bits that fall off the bottom on a right shift.
  always_comb begin
    y_c      = s1_lr ? (s1_x >> s1_shift) : (s1_x << s1_shift);
    sticky_c = s1_lr && (|(s1_x & ~({W{1'b1}} << s1_shift)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_shift  <= '0;
      out_lr     <= 1'b0;
      out_zero   <= 1'b0;
      out_sticky <= 1'b0;
      out_tag    <= '0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y      <= y_c;
        out_shift  <= s1_shift;
        out_lr     <= s1_lr;
        out_zero   <= s1_zero;
        out_sticky <= sticky_c;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_normalizer_pipe.sv
// Self-checking bench for normalizer_pipe: directed vectors, back-pressure, mid-flight reset and
// randomized streams on two parameterisations, checked against a behavioural model.
module tb_normalizer_pipe;

  typedef struct {
    logic [31:0] y;
    int          sh;
    logic        lr;
    logic        zero;
    logic        sticky;
    logic [31:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: W=18 F=12 TW=4
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [17:0] a_in_x, a_out_y;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [4:0]  a_out_shift;
  logic        a_out_lr, a_out_zero, a_out_sticky;

  // Instance B: W=24 F=8 TW=8
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_in_x, b_out_y;
  logic [7:0]  b_in_tag, b_out_tag;
  logic [4:0]  b_out_shift;
  logic        b_out_lr, b_out_zero, b_out_sticky;

  normalizer_pipe #(.W(18), .F(12), .TW(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y), .out_shift(a_out_shift),
    .out_lr(a_out_lr), .out_zero(a_out_zero), .out_sticky(a_out_sticky), .out_tag(a_out_tag)
  );

  normalizer_pipe #(.W(24), .F(8), .TW(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_shift(b_out_shift),
    .out_lr(b_out_lr), .out_zero(b_out_zero), .out_sticky(b_out_sticky), .out_tag(b_out_tag)
  );

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   alog_tag[$];
  int   alog_sh[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: find the leading one arithmetically and move it to bit f.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] tag, input int f);
    exp_t e;
    int   p;
    e.tag = tag; e.y = '0; e.sh = 0; e.lr = 1'b0; e.sticky = 1'b0; e.zero = (x == 32'd0);
    if (x != 32'd0) begin
      p = 0;
      while ((x >> (p + 1)) != 32'd0) p++;
      if (p > f) begin
        e.sh     = p - f;
        e.lr     = 1'b1;
        e.y      = x >> e.sh;
        e.sticky = (x % (32'd1 << e.sh)) != 32'd0;
      end else begin
        e.sh = f - p;
        e.y  = x << e.sh;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] v;
    v = $urandom & ((32'd1 << w) - 32'd1);
    if ($urandom_range(0, 9) == 0) v = '0;
    else v = v >> $urandom_range(0, w);
    return v;
  endfunction

  // Compare process: scoreboard both instances and enforce hold-stable outputs under stall.
  logic        a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  logic [63:0] a_prev, b_prev;
  int          a_results = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      a_prev_stall = 1'b0;
      b_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall)
        chk("a_stall_hold", 64'({a_out_valid, a_out_y, a_out_shift, a_out_lr, a_out_zero, a_out_sticky, a_out_tag}), a_prev);
      if (b_prev_stall)
        chk("b_stall_hold", 64'({b_out_valid, b_out_y, b_out_shift, b_out_lr, b_out_zero, b_out_sticky, b_out_tag}), b_prev);

      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_spurious_result actual=y%0h tag%0h required=none", a_out_y, a_out_tag);
        end else begin
          e = qa.pop_front();
          a_results++;
          chk("a_y", 64'(a_out_y), 64'(e.y));
          chk("a_shift", 64'(a_out_shift), 64'(e.sh));
          chk("a_flags", 64'({a_out_lr, a_out_zero, a_out_sticky}), 64'({e.lr, e.zero, e.sticky}));
          chk("a_tag", 64'(a_out_tag), 64'(e.tag));
          alog_tag.push_back(int'(a_out_tag));
          alog_sh.push_back(int'(a_out_shift));
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_spurious_result actual=y%0h tag%0h required=none", b_out_y, b_out_tag);
        end else begin
          e = qb.pop_front();
          chk("b_y", 64'(b_out_y), 64'(e.y));
          chk("b_shift", 64'(b_out_shift), 64'(e.sh));
          chk("b_flags", 64'({b_out_lr, b_out_zero, b_out_sticky}), 64'({e.lr, e.zero, e.sticky}));
          chk("b_tag", 64'(b_out_tag), 64'(e.tag));
        end
      end

      if (a_in_valid && a_in_ready) qa.push_back(model(32'(a_in_x), 32'(a_in_tag), 12));
      if (b_in_valid && b_in_ready) qb.push_back(model(32'(b_in_x), 32'(b_in_tag), 8));

      a_prev_stall = a_out_valid && !a_out_ready;
      b_prev_stall = b_out_valid && !b_out_ready;
      a_prev = 64'({a_out_valid, a_out_y, a_out_shift, a_out_lr, a_out_zero, a_out_sticky, a_out_tag});
      b_prev = 64'({b_out_valid, b_out_y, b_out_shift, b_out_lr, b_out_zero, b_out_sticky, b_out_tag});
    end
  end

  logic [17:0] dx  [5] = '{18'h01000, 18'h3F000, 18'h3FFFF, 18'h00001, 18'h00000};
  logic [17:0] dy  [5] = '{18'h01000, 18'h01F80, 18'h01FFF, 18'h01000, 18'h00000};
  int          dsh [5] = '{0, 5, 5, 12, 0};
  logic [2:0]  dfl [5] = '{3'b000, 3'b100, 3'b101, 3'b000, 3'b010};

  initial begin
    int   lat;
    int   idx;
    int   hold;
    int   stale;
    logic seen;
    logic sawdrop;
    exp_t e;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_x = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_x = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_outputs", 64'({a_out_valid, a_out_y, a_out_shift, a_out_lr, a_out_zero, a_out_sticky, a_out_tag}), 64'd0);
    chk("rst_b_outputs", 64'({b_out_valid, b_out_y, b_out_shift, b_out_lr, b_out_zero, b_out_sticky, b_out_tag}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);

    // Pin the model to hand-derived results.
    for (int i = 0; i < 5; i++) begin
      e = model(32'(dx[i]), 32'd0, 12);
      chk("model_y", 64'(e.y), 64'(dy[i]));
      chk("model_shift", 64'(e.sh), 64'(dsh[i]));
      chk("model_flags", 64'({e.lr, e.zero, e.sticky}), 64'(dfl[i]));
    end
    e = model(32'h00FFFFFF, 32'd0, 8);
    chk("model_b_full", 64'({e.y, 8'(e.sh), e.lr, e.sticky}), {32'h000001FF, 8'd15, 1'b1, 1'b1});

    // Directed vectors with latency measurement.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_x = dx[i]; a_in_tag = 4'(i + 3);
      @(negedge clk);
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("dir_latency", 64'(lat), 64'd2);
      chk("dir_y", 64'(a_out_y), 64'(dy[i]));
      chk("dir_shift", 64'(a_out_shift), 64'(dsh[i]));
      chk("dir_flags", 64'({a_out_lr, a_out_zero, a_out_sticky}), 64'(dfl[i]));
    end

    // Back-pressure: four operands, sink stalls 3 cycles after the first result.
    @(negedge clk);
    alog_tag.delete(); alog_sh.delete();
    idx = 0; hold = 0; seen = 1'b0; sawdrop = 1'b0;
    for (int cyc = 0; cyc < 40 && alog_tag.size() < 4; cyc++) begin
      @(negedge clk);
      if (a_out_valid && !seen) begin seen = 1'b1; hold = 3; end
      a_out_ready = (hold == 0);
      if (hold > 0) hold--;
      a_in_valid = (idx < 4);
      a_in_x = 18'(32'd1 << idx);
      a_in_tag = 4'(idx + 1);
      #2;
      if (a_in_valid && !a_in_ready) sawdrop = 1'b1;
      if (a_in_valid && a_in_ready) idx++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("bp_in_ready_dropped", 64'(sawdrop), 64'd1);
    chk("bp_count", 64'(alog_tag.size()), 64'd4);
    for (int i = 0; i < 4 && i < alog_tag.size(); i++) begin
      chk("bp_tag_order", 64'(alog_tag[i]), 64'(i + 1));
      chk("bp_shift", 64'(alog_sh[i]), 64'(12 - i));
    end

    // Reset with both stages full.
    @(negedge clk);
    a_out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_x = 18'(rnd(18)); a_in_tag = 4'($urandom);
      #2;
      if (!a_in_ready) break;
    end
    chk("rst_fill_full", 64'({a_out_valid, a_in_ready}), 64'b10);
    @(negedge clk);
    a_in_valid = 1'b0; rst = 1'b1;
    qa.delete(); qb.delete();
    @(negedge clk);
    chk("midrst_outputs", 64'({a_out_valid, a_out_y, a_out_shift, a_out_lr, a_out_zero, a_out_sticky, a_out_tag}), 64'd0);
    chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
    #2;
    rst = 1'b0; a_out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_out_valid) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);

    // Randomized streams on both instances.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_in_x = 18'(rnd(18)); a_in_tag = 4'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = ($urandom_range(0, 2) != 0);
      b_in_x = 24'(rnd(24)); b_in_tag = 8'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_a_empty", 64'(qa.size()), 64'd0);
    chk("drain_b_empty", 64'(qb.size()), 64'd0);
    chk("a_results_seen", 64'(a_results > 500), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
